demux1x8_8_buf: RTL and testbench



---
 rtl/ops8_pkg.sv | 22 ++
 rtl/demux_chan.sv | 28 ++
 rtl/demux1x8_8_buf.sv | 90 +++++++++
 tb/tb_demux1x8_8_buf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ops8_pkg.sv
// Shared definitions for the 8-bit byte-ops blocks (byte mux, byte demux).
// Channel count, select width, byte type and small decode helpers.
package ops8_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef logic [7:0] byte_t;

    // One-hot decode of a channel index
    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] cur);
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/demux_chan.sv
// One buffered demux channel: output register plus its full flag.
// A write in the same cycle as an ack wins, so the flag stays set (write-through).
module demux_chan #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] d,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VAL;
            full <= 1'b0;
        end else if (wr) begin
            q    <= d;
            full <= 1'b1;
        end else if (ack && full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1x8_8_buf.sv
// Registered 1-to-8 byte demux with per-channel full flags and round-robin pointer.
// Optional broadcast mode is enabled by defining DEMUX_BCAST_EN.
module demux1x8_8_buf
    import ops8_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    input  logic             auto,
`ifdef DEMUX_BCAST_EN
    input  logic             bcast,
`endif
    input  logic [N_CH-1:0]  ack,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [N_CH-1:0]  full,
    output logic [SEL_W-1:0] ptr
);

    logic [SEL_W-1:0] target;
    logic [N_CH-1:0]  free_vec;
    logic [N_CH-1:0]  wr_vec;
    logic             accept;
    logic             bcast_on;
    logic [WIDTH-1:0] q_arr [N_CH];

    // A channel can take a byte if it is empty or being drained this cycle
    always_comb begin
`ifdef DEMUX_BCAST_EN
        bcast_on = bcast;
`else
        bcast_on = 1'b0;
`endif
        target   = auto ? ptr : {s2, s1, s0};
        free_vec = ~full | ack;
        i_ready  = bcast_on ? (&free_vec) : free_vec[target];
        accept   = i_valid & i_ready;
        wr_vec   = '0;
        if (accept) begin
            wr_vec = bcast_on ? {N_CH{1'b1}} : onehot(target);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && auto && !bcast_on) begin
            ptr <= next_ptr(ptr);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        demux_chan #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .wr   (wr_vec[k]),
            .d    (i),
            .ack  (ack[k]),
            .q    (q_arr[k]),
            .full (full[k])
        );
    end

    assign o0 = q_arr[0];
    assign o1 = q_arr[1];
    assign o2 = q_arr[2];
    assign o3 = q_arr[3];
    assign o4 = q_arr[4];
    assign o5 = q_arr[5];
    assign o6 = q_arr[6];
    assign o7 = q_arr[7];

endmodule

// File: tb/tb_demux1x8_8_buf.sv
// Self-checking bench for demux1x8_8_buf: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_demux1x8_8_buf;

    logic       clk;
    logic       rst;
    logic [7:0] i;
    logic       i_valid;
    logic       i_ready;
    logic       s2, s1, s0;
    logic       auto;
    logic       bcast;
    logic [7:0] ack;
    logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0] full;
    logic [2:0] ptr;

    logic [7:0] dut_o [8];

    int checks;
    int errors;

    logic [7:0] m_q [8];
    logic [7:0] m_full;
    logic [2:0] m_ptr;
    logic       last_ready;

    demux1x8_8_buf dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .s2      (s2),
        .s1      (s1),
        .s0      (s0),
        .auto    (auto),
`ifdef DEMUX_BCAST_EN
        .bcast   (bcast),
`endif
        .ack     (ack),
        .o0      (o0),
        .o1      (o1),
        .o2      (o2),
        .o3      (o3),
        .o4      (o4),
        .o5      (o5),
        .o6      (o6),
        .o7      (o7),
        .full    (full),
        .ptr     (ptr)
    );

    assign dut_o[0] = o0;
    assign dut_o[1] = o1;
    assign dut_o[2] = o2;
    assign dut_o[3] = o3;
    assign dut_o[4] = o4;
    assign dut_o[5] = o5;
    assign dut_o[6] = o6;
    assign dut_o[7] = o7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: checks i_ready before the edge, updates the model
    // at the edge, then checks every registered output after it.
    task automatic cycle(input logic r, input logic v, input logic a, input logic b,
                         input logic [2:0] sel, input logic [7:0] ak, input logic [7:0] d);
        logic       eb;
        logic [2:0] t;
        logic       exp_rdy;
        logic       acc;
        rst     = r;
        i_valid = v;
        auto    = a;
        {s2, s1, s0} = sel;
        ack     = ak;
        i       = d;
        bcast   = b;
`ifdef DEMUX_BCAST_EN
        eb = b;
`else
        eb = 1'b0;
`endif
        t = a ? m_ptr : sel;
        if (eb) exp_rdy = ((~m_full | ak) == 8'hFF);
        else    exp_rdy = ~m_full[t] | ak[t];
        acc = v & exp_rdy;
        #1;
        last_ready = i_ready;
        check("i_ready", {31'd0, i_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 8; k++) m_q[k] = 8'h00;
            m_full = 8'h00;
            m_ptr  = 3'd0;
        end else begin
            m_full = m_full & ~ak;
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    if (eb || (k == int'(t))) begin
                        m_q[k]    = d;
                        m_full[k] = 1'b1;
                    end
                end
                if (a && !eb) m_ptr = 3'((int'(m_ptr) + 1) % 8);
            end
        end
        #1;
        for (int k = 0; k < 8; k++)
            check($sformatf("o%0d", k), {24'd0, dut_o[k]}, {24'd0, m_q[k]});
        check("full", {24'd0, full}, {24'd0, m_full});
        check("ptr", {29'd0, ptr}, {29'd0, m_ptr});
    endtask

    task automatic applyStimulus();
        // Reset with a byte offered: it must be dropped
        cycle(1, 1, 0, 0, 3'd5, 8'h00, 8'hFF);
        cycle(1, 1, 0, 0, 3'd5, 8'h00, 8'hFF);
        check("rst_full", {24'd0, full}, 32'h00);
        check("rst_o5", {24'd0, o5}, 32'h00);
        check("rst_ptr", {29'd0, ptr}, 32'h0);

        cycle(0, 1, 0, 0, 3'd5, 8'h00, 8'hA5);
        check("a5_o5", {24'd0, o5}, 32'hA5);
        check("a5_full", {24'd0, full}, 32'h20);
        check("a5_o4", {24'd0, o4}, 32'h00);
        cycle(0, 0, 0, 0, 3'd5, 8'h00, 8'h00);
        check("sel5_stall", {31'd0, last_ready}, 32'h0);
        cycle(0, 0, 0, 0, 3'd0, 8'h20, 8'h00);
        check("clr5_full", {24'd0, full}, 32'h00);

        // Round-robin stream of nine bytes, the ninth must stall
        for (int n = 0; n < 8; n++)
            cycle(0, 1, 1, 0, 3'd0, 8'h00, 8'(8'h10 + n));
        check("rr_full", {24'd0, full}, 32'hFF);
        check("rr_ptr", {29'd0, ptr}, 32'h0);
        check("rr_o7", {24'd0, o7}, 32'h17);
        cycle(0, 1, 1, 0, 3'd0, 8'h00, 8'h18);
        check("rr_stall", {31'd0, last_ready}, 32'h0);
        check("rr_stall_o0", {24'd0, o0}, 32'h10);
        cycle(0, 1, 1, 0, 3'd0, 8'h01, 8'h18);
        check("rr_go", {31'd0, last_ready}, 32'h1);
        check("rr_o0", {24'd0, o0}, 32'h18);
        check("rr_ptr1", {29'd0, ptr}, 32'h1);

        // Write-through on channel 3
        cycle(0, 1, 0, 0, 3'd3, 8'h08, 8'h3C);
        check("wt_ready", {31'd0, last_ready}, 32'h1);
        check("wt_o3", {24'd0, o3}, 32'h3C);
        check("wt_full", {24'd0, full}, 32'hFF);

        cycle(0, 0, 0, 0, 3'd0, 8'h7E, 8'h00);
        check("part_full", {24'd0, full}, 32'h81);
        cycle(0, 0, 0, 0, 3'd0, 8'h81, 8'h00);
        check("ack81_full", {24'd0, full}, 32'h00);
        check("ack81_o0", {24'd0, o0}, 32'h18);
        check("ack81_o7", {24'd0, o7}, 32'h17);
        cycle(0, 0, 0, 0, 3'd0, 8'h04, 8'h00);
        check("idle_ack_full", {24'd0, full}, 32'h00);
        check("idle_ack_o2", {24'd0, o2}, 32'h12);

        // Reset beats an accept to channel 6 with ptr=4
        for (int n = 0; n < 3; n++)
            cycle(0, 1, 1, 0, 3'd0, 8'h00, 8'(8'h40 + n));
        check("ptr4", {29'd0, ptr}, 32'h4);
        cycle(1, 1, 0, 0, 3'd6, 8'h00, 8'hEE);
        check("rstacc_o6", {24'd0, o6}, 32'h00);
        check("rstacc_full", {24'd0, full}, 32'h00);
        check("rstacc_ptr", {29'd0, ptr}, 32'h0);

`ifdef DEMUX_BCAST_EN
        cycle(0, 1, 1, 0, 3'd0, 8'h00, 8'h77);
        cycle(0, 1, 0, 1, 3'd0, 8'h00, 8'h5A);
        check("bc_stall", {31'd0, last_ready}, 32'h0);
        cycle(0, 1, 0, 1, 3'd0, 8'h01, 8'h5A);
        check("bc_go", {31'd0, last_ready}, 32'h1);
        check("bc_o4", {24'd0, o4}, 32'h5A);
        check("bc_full", {24'd0, full}, 32'hFF);
        check("bc_ptr", {29'd0, ptr}, 32'h1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++)
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 9) == 0,
                  3'($urandom), 8'($urandom & $urandom & $urandom), 8'($urandom));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_full  = 8'h00;
        m_ptr   = 3'd0;
        for (int k = 0; k < 8; k++) m_q[k] = 8'h00;
        rst = 1'b1; i = 8'h00; i_valid = 1'b0; auto = 1'b0; bcast = 1'b0;
        s2 = 1'b0; s1 = 1'b0; s0 = 1'b0; ack = 8'h00;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
